// File: rtl/ps2_keycode.sv
// PS/2 keyboard receiver: frames 11-bit PS/2 bytes and tracks the currently held key,
// handling E0 (extended) and F0 (break) prefixes.
module ps2_keycode #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       extended,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [7:0]    shift, shift_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic          par_bit, par_bit_nxt;
  logic [TW-1:0] tmo_cnt;
  logic          ext_pending, brk_pending;

  logic clk_s1, clk_s2, clk_prev;
  logic data_s1, data_s2;
  logic fall_c, accept_c, err_c, timeout_c;

  // Two-flop synchronisers, preset to the idle-high bus level
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data;
      data_s2  <= data_s1;
    end
  end

  assign fall_c    = clk_prev & ~clk_s2;
  assign timeout_c = (state != IDLE) && !fall_c && (tmo_cnt == TW'(TIMEOUT_CYCLES));

  // Frame sequencing; a timeout overrides whatever the frame logic decided
  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift;
    bit_cnt_nxt = bit_cnt;
    par_bit_nxt = par_bit;
    accept_c    = 1'b0;
    err_c       = 1'b0;
    case (state)
      IDLE: if (fall_c && !data_s2) begin
        state_nxt   = DATA;
        bit_cnt_nxt = 3'd0;
      end
      DATA: if (fall_c) begin
        shift_nxt   = {data_s2, shift[7:1]};
        bit_cnt_nxt = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) state_nxt = PARITY;
      end
      PARITY: if (fall_c) begin
        par_bit_nxt = data_s2;
        state_nxt   = STOP;
      end
      default: if (fall_c) begin
        state_nxt = IDLE;
        if (data_s2 && ((^shift) ^ par_bit)) accept_c = 1'b1;
        else                                 err_c    = 1'b1;
      end
    endcase
    if (timeout_c) begin
      state_nxt = IDLE;
      accept_c  = 1'b0;
      err_c     = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      shift   <= 8'h00;
      bit_cnt <= 3'd0;
      par_bit <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      state   <= state_nxt;
      shift   <= shift_nxt;
      bit_cnt <= bit_cnt_nxt;
      par_bit <= par_bit_nxt;
      if (state == IDLE || fall_c)           tmo_cnt <= '0;
      else if (tmo_cnt != TW'(TIMEOUT_CYCLES)) tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // Scan-code decode of accepted bytes
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      keycode     <= 8'h00;
      extended    <= 1'b0;
      byte_valid  <= 1'b0;
      frame_err   <= 1'b0;
      ext_pending <= 1'b0;
      brk_pending <= 1'b0;
    end else begin
      byte_valid <= accept_c;
      frame_err  <= err_c;
      if (err_c) begin
        ext_pending <= 1'b0;
        brk_pending <= 1'b0;
      end else if (accept_c) begin
        if (shift == 8'hE0) begin
          ext_pending <= 1'b1;
        end else if (shift == 8'hF0) begin
          brk_pending <= 1'b1;
        end else begin
          if (!brk_pending) begin
            keycode  <= shift;
            extended <= ext_pending;
          end else if (shift == keycode && ext_pending == extended) begin
            keycode  <= 8'h00;
            extended <= 1'b0;
          end
          ext_pending <= 1'b0;
          brk_pending <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keycode.sv
// Randomised self-checking bench for ps2_keycode against a scan-code-level key model.
module tb_ps2_keycode;

  localparam int unsigned TMO  = 200;
  localparam int unsigned HALF = 8;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] keycode;
  logic       extended, byte_valid, frame_err;

  int tests_run = 0;
  int tests_failed = 0;
  int bv_cnt = 0;
  int fe_cnt = 0;

  // Model of the held key and prefix state
  logic [7:0] m_key = 8'h00;
  logic       m_ext = 1'b0, m_extp = 1'b0, m_brkp = 1'b0;

  ps2_keycode #(.TIMEOUT_CYCLES(TMO)) dut (
    .Clk(Clk), .Reset(Reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keycode(keycode), .extended(extended),
    .byte_valid(byte_valid), .frame_err(frame_err)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (byte_valid) bv_cnt++;
    if (frame_err)  fe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input bit good);
    if (!good) begin
      m_extp = 1'b0; m_brkp = 1'b0;
    end else if (b == 8'hE0) m_extp = 1'b1;
    else if (b == 8'hF0)     m_brkp = 1'b1;
    else begin
      if (!m_brkp) begin
        m_key = b; m_ext = m_extp;
      end else if (m_key == b && m_ext == m_extp) begin
        m_key = 8'h00; m_ext = 1'b0;
      end
      m_extp = 1'b0; m_brkp = 1'b0;
    end
  endtask

  task automatic ps2_bit(input logic v);
    @(negedge Clk) ps2_data = v;
    repeat (HALF) @(negedge Clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge Clk);
    ps2_clk = 1'b1;
  endtask

  // Send one frame and check outputs against the model afterwards
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic [10:0] bits;
    int bv0, fe0;
    bit good;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    bv0 = bv_cnt; fe0 = fe_cnt;
    for (int i = 0; i < 11; i++) ps2_bit(bits[i]);
    repeat (6) @(negedge Clk);
    good = !bad_par && !bad_stop;
    model_byte(b, good);
    check($sformatf("byte_valid[%02h]", b), 32'(bv_cnt - bv0), good ? 1 : 0);
    check($sformatf("frame_err[%02h]", b),  32'(fe_cnt - fe0), good ? 0 : 1);
    check($sformatf("keycode[%02h]", b),    32'(keycode), 32'(m_key));
    check($sformatf("extended[%02h]", b),   32'(extended), 32'(m_ext));
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    #1;
    m_key = 8'h00; m_ext = 1'b0; m_extp = 1'b0; m_brkp = 1'b0;
    check("rst_keycode", 32'(keycode), 0);
    check("rst_extended", 32'(extended), 0);
    check("rst_byte_valid", 32'(byte_valid), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
  endtask

  logic [7:0] keys[6] = '{8'h1C, 8'h23, 8'h75, 8'h1B, 8'h6B, 8'h5A};

  initial begin
    int fe0;
    do_reset();

    // Make, break, extended make/break
    send_frame(8'h1C, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_frame(8'h75, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);

    // Parity error leaves key held; stop-bit error too
    send_frame(8'h1C, 0, 0);
    send_frame(8'h1C, 1, 0);
    send_frame(8'h1C, 0, 1);
    // Typematic repeat keeps the key held
    send_frame(8'h1C, 0, 0);

    // Timeout after start + 4 data bits
    fe0 = fe_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (TMO + 20) @(negedge Clk);
    model_byte(8'h00, 0);
    check("timeout_frame_err", 32'(fe_cnt - fe0), 1);
    check("timeout_state_idle", 32'(dut.state), 0);
    send_frame(8'h1C, 0, 0);

    // Non-matching break keeps key
    send_frame(8'hF0, 0, 0);
    send_frame(8'h23, 0, 0);

    // Reset mid-frame, then a fresh frame
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1);
    do_reset();
    send_frame(8'h1C, 0, 0);

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      logic [7:0] b;
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 2)      b = 8'hE0;
      else if (sel < 4) b = 8'hF0;
      else if (sel < 8) b = keys[$urandom_range(0, 5)];
      else              b = 8'($urandom);
      send_frame(b, ($urandom_range(0, 9) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/ps2_keycode.md
PS2_KEYCODE -- requirements
Module: ps2_keycode

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, the maximum number of Clk cycles allowed between PS/2 falling edges inside a frame.
REQ-002 SHALL have port Clk, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port ps2_clk, input, 1 bit, the keyboard clock, asynchronous to Clk.
REQ-005 SHALL have port ps2_data, input, 1 bit, the keyboard data, asynchronous to Clk.
REQ-006 SHALL have port keycode, output, 8 bits, the make code of the currently held key; 0 when no key is held.
REQ-007 SHALL have port extended, output, 1 bit, high when the held keycode was preceded by an E0 prefix.
REQ-008 SHALL have port byte_valid, output, 1 bit, one-cycle pulse for each correctly received byte.
REQ-009 SHALL have port frame_err, output, 1 bit, one-cycle pulse on a parity error, stop-bit error or timeout.

Function
REQ-010 SHALL synchronise ps2_clk and ps2_data through two flip-flops each before any use.
REQ-011 SHALL detect a ps2_clk falling edge as synchronised previous sample 1 and current sample 0, and SHALL sample ps2_data only on that cycle.
REQ-012 SHALL use the FSM states IDLE, DATA, PARITY and STOP.
REQ-013 SHALL, in IDLE, move to DATA on a falling edge with data 0 (start bit), and SHALL ignore a falling edge with data 1.
REQ-014 SHALL, in DATA, shift in 8 bits LSB first using a 3-bit counter, then move to PARITY.
REQ-015 SHALL, in PARITY, capture the parity bit and move to STOP.
REQ-016 SHALL check for odd parity: the XOR of the 8 data bits and the parity bit equals 1.
REQ-017 SHALL, in STOP, return to IDLE on the next falling edge.
  - Stop bit 1 and parity good: byte accepted, byte_valid pulses.
  - Otherwise: frame_err pulses and the byte is discarded.
REQ-018 SHALL clear the timeout counter on every falling edge and increment it on other cycles outside IDLE.
REQ-019 SHALL, when the timeout counter reaches TIMEOUT_CYCLES outside IDLE, pulse frame_err, go to IDLE and discard the partial byte.
REQ-020 SHALL handle an accepted byte of 0xE0 by setting an internal ext_pending flag, with keycode unchanged.
REQ-021 SHALL handle an accepted byte of 0xF0 by setting an internal brk_pending flag, with keycode unchanged.
REQ-022 SHALL handle any other accepted byte B with brk_pending=0 as a make code:
  - keycode <= B;
  - extended <= ext_pending;
  - both pending flags are cleared.
REQ-023 SHALL handle any other accepted byte B with brk_pending=1 as a break code:
  - If B equals keycode and ext_pending equals extended: keycode <= 0 and extended <= 0.
  - Otherwise: keycode is unchanged.
  - In either case both pending flags are cleared.
REQ-024 SHALL treat a repeated make of the currently held key (typematic) as rewriting the same value, so keycode stays constant with no glitch to 0.
REQ-025 SHALL clear both pending flags when a frame error occurs.
REQ-026 SHALL make keycode, extended, byte_valid and frame_err registered outputs.
REQ-027 SHALL assert keycode and byte_valid on the first Clk edge after the STOP-state falling edge is detected (latency 1 cycle from that detection).

Reset
REQ-028 SHALL, while Reset=0, immediately force:
  - FSM to IDLE;
  - shift register, bit counter and timeout counter to 0;
  - pending flags to 0;
  - keycode=0x00, extended=0, byte_valid=0, frame_err=0.
REQ-029 SHALL, when Reset is asserted mid-frame, discard the partial frame, and the next start bit after deassertion SHALL begin a fresh frame.
REQ-030 SHALL preset the synchroniser flip-flops to 1 (bus idle) on reset, so deassertion creates no false falling edge.

Verification
REQ-031 SHALL cover make: frame 0x1C with parity 0 and stop 1 -> byte_valid one pulse, keycode=0x1C, extended=0.
REQ-032 SHALL cover break: frames F0 then 1C after the make of 0x1C -> two byte_valid pulses, keycode=0x00 after the second frame.
REQ-033 SHALL cover extended: frames E0 then 75 -> keycode=0x75, extended=1; then E0 F0 75 -> keycode=0x00, extended=0.
REQ-034 SHALL cover parity error: frame 0x1C with parity bit 1 -> frame_err one pulse, no byte_valid, keycode unchanged.
REQ-035 SHALL cover timeout: start bit plus 4 data bits, then ps2_clk held high for TIMEOUT_CYCLES -> frame_err pulse, FSM in IDLE; a following valid 0x1C frame is decoded correctly.
REQ-036 SHALL cover non-matching break and reset: with keycode=0x1C, frames F0 then 23 -> keycode stays 0x1C; then Reset low mid-frame -> keycode=0x00 at once.
